// File: rtl/zoom_pkg.sv
// Encodings and source-frame constants shared by the scan controller and the ula mapper.
package zoom_pkg;

   localparam int unsigned SRC_WIDTH  = 320;
   localparam int unsigned SRC_HEIGHT = 240;

   localparam logic [2:0] OP_NORMAL = 3'b000;
   localparam logic [2:0] OP_ZIN    = 3'b100;
   localparam logic [2:0] OP_ZOUT   = 3'b010;

   typedef enum logic [1:0] {
      ZL_NORMAL,
      ZL_ZIN,
      ZL_ZOUT
   } zoom_level_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DRAIN,
      ST_DONE
   } ctrl_state_e;

   function automatic logic [2:0] level_to_op(zoom_level_e lvl);
      logic [2:0] op;
      case (lvl)
         ZL_ZIN:  op = OP_ZIN;
         ZL_ZOUT: op = OP_ZOUT;
         default: op = OP_NORMAL;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/zoom_scan_ctrl_if.sv
// Ready/valid pixel stream from the scan controller to the VGA pixel FIFO.
interface zoom_scan_ctrl_if #(
   parameter int unsigned PIX_W = 8
) ();

   logic [PIX_W-1:0] pix_data;
   logic             pix_valid;
   logic             pix_ready;
   logic             pix_sof;
   logic             pix_eol;

   modport master (
      output pix_data,
      output pix_valid,
      output pix_sof,
      output pix_eol,
      input  pix_ready
   );

   modport slave (
      input  pix_data,
      input  pix_valid,
      input  pix_sof,
      input  pix_eol,
      output pix_ready
   );

endinterface

// File: rtl/zoom_level_fsm.sv
// Zoom level tracking: buttons edit a pending level, which becomes the active op on commit.
module zoom_level_fsm
   import zoom_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       zoom_in_btn,
   input  logic       zoom_out_btn,
   input  logic       commit,
   output logic [2:0] ula_op
);

   zoom_level_e pend_q, pend_d;
   zoom_level_e active_q, active_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         pend_q   <= ZL_NORMAL;
         active_q <= ZL_NORMAL;
      end else begin
         pend_q   <= pend_d;
         active_q <= active_d;
      end
   end

   // Simultaneous presses cancel out; commit takes the level as it stood before this cycle's press.
   always_comb begin
      pend_d   = pend_q;
      active_d = active_q;
      if (zoom_in_btn && !zoom_out_btn) begin
         case (pend_q)
            ZL_NORMAL: pend_d = ZL_ZIN;
            ZL_ZOUT:   pend_d = ZL_NORMAL;
            default:   pend_d = pend_q;
         endcase
      end else if (zoom_out_btn && !zoom_in_btn) begin
         case (pend_q)
            ZL_NORMAL: pend_d = ZL_ZOUT;
            ZL_ZIN:    pend_d = ZL_NORMAL;
            default:   pend_d = pend_q;
         endcase
      end
      if (commit) begin
         active_d = pend_q;
      end
   end

   always_comb begin
      ula_op = level_to_op(active_q);
   end

endmodule

// File: rtl/zoom_scan_ctrl.sv
// Frame-scan controller: walks the output raster through the ula mapper and frame buffer
// and emits one zoomed frame as a three-stage ready/valid pixel stream.
module zoom_scan_ctrl
   import zoom_pkg::*;
#(
   parameter int unsigned      H_ACTIVE = 640,
   parameter int unsigned      V_ACTIVE = 480,
   parameter int unsigned      SRC_W    = SRC_WIDTH,
   parameter int unsigned      SRC_H    = SRC_HEIGHT,
   parameter int unsigned      PIX_W    = 8,
   parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              zoom_in_btn,
   input  logic              zoom_out_btn,
   output logic [9:0]        ula_x_in,
   output logic [9:0]        ula_y_in,
   output logic [2:0]        ula_op,
   input  logic [9:0]        ula_x_out,
   input  logic [9:0]        ula_y_out,
   input  logic [16:0]       ula_address,
   output logic [16:0]       mem_addr,
   output logic              mem_rd_en,
   input  logic [PIX_W-1:0]  mem_data,
   zoom_scan_ctrl_if.master  pix,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [9:0] X_LAST    = 10'(H_ACTIVE - 1);
   localparam logic [9:0] Y_LAST    = 10'(V_ACTIVE - 1);
   localparam logic [9:0] SRC_W_LIM = 10'(SRC_W);
   localparam logic [9:0] SRC_H_LIM = 10'(SRC_H);

   ctrl_state_e state_q, state_d;
   logic [9:0]  x_q, x_d, y_q, y_d;

   logic        s1_valid_q, s1_in_range_q, s1_sof_q, s1_eol_q;
   logic [16:0] mem_addr_q;
   logic        s2_valid_q, s2_in_range_q, s2_sof_q, s2_eol_q;

   logic adv;
   logic scan_en;
   logic last_issue;
   logic commit;

   assign adv        = !(s2_valid_q && !pix.pix_ready);
   assign last_issue = scan_en && adv && (x_q == X_LAST) && (y_q == Y_LAST);
   assign commit     = (state_q == ST_IDLE) && start;

   zoom_level_fsm u_level (
      .clock        (clock),
      .reset        (reset),
      .zoom_in_btn  (zoom_in_btn),
      .zoom_out_btn (zoom_out_btn),
      .commit       (commit),
      .ula_op       (ula_op)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DRAIN ends once both pipeline stages have emptied, i.e. the cycle after the last accept.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_SCAN;
         ST_SCAN:  if (last_issue) state_d = ST_DRAIN;
         ST_DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      scan_en    = (state_q == ST_SCAN);
      busy       = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
      frame_done = (state_q == ST_DONE);
   end

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (scan_en && adv) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q    <= 1'b0;
         s1_in_range_q <= 1'b0;
         s1_sof_q      <= 1'b0;
         s1_eol_q      <= 1'b0;
         mem_addr_q    <= '0;
         s2_valid_q    <= 1'b0;
         s2_in_range_q <= 1'b0;
         s2_sof_q      <= 1'b0;
         s2_eol_q      <= 1'b0;
      end else if (adv) begin
         s1_valid_q <= scan_en;
         s1_sof_q   <= scan_en && (x_q == '0) && (y_q == '0);
         s1_eol_q   <= scan_en && (x_q == X_LAST);
         if (scan_en) begin
            mem_addr_q    <= ula_address;
            s1_in_range_q <= (ula_x_out < SRC_W_LIM) && (ula_y_out < SRC_H_LIM);
         end
         s2_valid_q    <= s1_valid_q;
         s2_in_range_q <= s1_in_range_q;
         s2_sof_q      <= s1_sof_q;
         s2_eol_q      <= s1_eol_q;
      end
   end

   assign ula_x_in  = x_q;
   assign ula_y_in  = y_q;
   assign mem_addr  = mem_addr_q;
   assign mem_rd_en = s1_valid_q && adv;

   // RAM data holds while mem_rd_en is low, so pix_data stays stable through a stall.
   assign pix.pix_data  = s2_valid_q ? (s2_in_range_q ? mem_data : BG_COLOR) : '0;
   assign pix.pix_valid = s2_valid_q;
   assign pix.pix_sof   = s2_sof_q;
   assign pix.pix_eol   = s2_eol_q;

endmodule

// File: tb/tb_zoom_scan_ctrl.sv
// Directed bench for zoom_scan_ctrl on a reduced raster, with a golden ula/RAM and a pixel scoreboard.
module tb_zoom_scan_ctrl;
   import zoom_pkg::*;

   localparam int unsigned H  = 16;
   localparam int unsigned V  = 12;
   localparam int unsigned SW = 8;
   localparam int unsigned SH = 6;
   localparam int unsigned PW = 8;
   localparam logic [7:0]  BG = 8'hA5;

   typedef struct packed {
      logic [7:0] data;
      logic       sof;
      logic       eol;
      logic       last;
      logic [2:0] op;
   } sb_entry_t;

   logic        clock = 1'b0;
   logic        reset, start, zin, zout;
   logic [9:0]  ula_x_in, ula_y_in, ula_x_out, ula_y_out;
   logic [2:0]  ula_op;
   logic [16:0] ula_address, mem_addr;
   logic        mem_rd_en;
   logic [7:0]  mem_data = '0;
   logic        busy, frame_done;

   zoom_scan_ctrl_if #(.PIX_W(PW)) pix_if ();

   zoom_scan_ctrl #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .SRC_W    (SW),
      .SRC_H    (SH),
      .PIX_W    (PW),
      .BG_COLOR (BG)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .zoom_in_btn  (zin),
      .zoom_out_btn (zout),
      .ula_x_in     (ula_x_in),
      .ula_y_in     (ula_y_in),
      .ula_op       (ula_op),
      .ula_x_out    (ula_x_out),
      .ula_y_out    (ula_y_out),
      .ula_address  (ula_address),
      .mem_addr     (mem_addr),
      .mem_rd_en    (mem_rd_en),
      .mem_data     (mem_data),
      .pix          (pix_if),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Golden mapper: normal halves, zoom-in is a centred 1:1 crop, zoom-out shows the source 1:1 at the top-left.
   function automatic logic [19:0] map_xy(logic [2:0] op, logic [9:0] x, logic [9:0] y);
      logic [9:0] xo, yo;
      case (op)
         OP_ZIN:  begin xo = x - 10'(H / 4); yo = y - 10'(V / 4); end
         OP_ZOUT: begin xo = x;              yo = y;              end
         default: begin xo = x >> 1;         yo = y >> 1;         end
      endcase
      return {xo, yo};
   endfunction

   function automatic logic [7:0] ram_f(logic [16:0] a);
      return 8'(a * 13 + 7);
   endfunction

   function automatic logic [7:0] exp_pix(logic [2:0] op, logic [9:0] x, logic [9:0] y);
      logic [9:0] xo, yo;
      {xo, yo} = map_xy(op, x, y);
      if (xo < 10'(SW) && yo < 10'(SH)) return ram_f(17'(yo * SW + xo));
      return BG;
   endfunction

   always_comb begin
      {ula_x_out, ula_y_out} = map_xy(ula_op, ula_x_in, ula_y_in);
      ula_address = 17'(ula_y_out * SW + ula_x_out);
   end

   always @(posedge clock) if (mem_rd_en) mem_data <= ram_f(mem_addr);

   sb_entry_t sb_q[$];

   task automatic push_frame(input logic [2:0] op);
      sb_entry_t e;
      for (int y = 0; y < int'(V); y++) begin
         for (int x = 0; x < int'(H); x++) begin
            e.data = exp_pix(op, 10'(x), 10'(y));
            e.sof  = (x == 0) && (y == 0);
            e.eol  = (x == int'(H) - 1);
            e.last = (x == int'(H) - 1) && (y == int'(V) - 1);
            e.op   = op;
            sb_q.push_back(e);
         end
      end
   endtask

   bit         stall_en = 1'b0;
   int         first_vld_cyc = 0, first_rd_cyc = 0, last_cyc = 0, acc_cnt = 0, fd_cnt = 0;
   bit         sof_seen = 1'b0, rd_seen = 1'b0, prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   logic       prev_sof = 1'b0, prev_eol = 1'b0;

   initial begin
      pix_if.pix_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         pix_if.pix_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clock) begin : mon
      sb_entry_t e;
      if (reset) begin
         prev_stall = 1'b0;
         sof_seen   = 1'b0;
         rd_seen    = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", pix_if.pix_valid, 1);
            check("stall_data", pix_if.pix_data, prev_data);
            check("stall_sof", pix_if.pix_sof, prev_sof);
            check("stall_eol", pix_if.pix_eol, prev_eol);
         end
         if (pix_if.pix_valid && !pix_if.pix_ready) check("stall_rd_en", mem_rd_en, 0);
         if (mem_rd_en && !rd_seen) begin
            rd_seen      = 1'b1;
            first_rd_cyc = cyc;
         end
         if (pix_if.pix_valid && pix_if.pix_sof && !sof_seen) begin
            sof_seen      = 1'b1;
            first_vld_cyc = cyc;
         end
         if (pix_if.pix_valid && pix_if.pix_ready) begin
            check("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("pix_data", pix_if.pix_data, e.data);
               check("pix_sof", pix_if.pix_sof, e.sof);
               check("pix_eol", pix_if.pix_eol, e.eol);
               check("ula_op_frame", ula_op, e.op);
               if (e.last) last_cyc = cyc;
            end
            acc_cnt++;
         end
         if (frame_done) begin
            fd_cnt++;
            sof_seen = 1'b0;
            rd_seen  = 1'b0;
         end
         prev_stall = pix_if.pix_valid && !pix_if.pix_ready;
         prev_data  = pix_if.pix_data;
         prev_sof   = pix_if.pix_sof;
         prev_eol   = pix_if.pix_eol;
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_x_in"}, ula_x_in, 0);
      check({tag, "_y_in"}, ula_y_in, 0);
      check({tag, "_op"}, ula_op, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_rd_en"}, mem_rd_en, 0);
      check({tag, "_pix_data"}, pix_if.pix_data, 0);
      check({tag, "_pix_valid"}, pix_if.pix_valid, 0);
      check({tag, "_pix_sof"}, pix_if.pix_sof, 0);
      check({tag, "_pix_eol"}, pix_if.pix_eol, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_frame_done"}, frame_done, 0);
   endtask

   task automatic pulse_btn(input logic i, input logic o);
      @(negedge clock);
      zin  = i;
      zout = o;
      @(negedge clock);
      zin  = 1'b0;
      zout = 1'b0;
   endtask

   task automatic run_frame(input logic [2:0] op, input bit stall, input bit mid_zin, input bit mid_start);
      int st_cyc, fd0;
      fd0 = fd_cnt;
      push_frame(op);
      stall_en = stall;
      @(posedge clock);
      #1 start = 1'b1;
      st_cyc = cyc;
      @(posedge clock);
      #1 start = 1'b0;
      @(negedge clock);
      check("op_at_start", ula_op, op);
      check("busy_scan", busy, 1);
      for (int n = 0; n < 4000; n++) begin
         @(negedge clock);
         if (frame_done) break;
         if (n == 40) begin
            zin   = mid_zin;
            start = mid_start;
         end else begin
            zin   = 1'b0;
            start = 1'b0;
         end
      end
      zin   = 1'b0;
      start = 1'b0;
      check("frame_done_seen", frame_done, 1);
      check("op_held", ula_op, op);
      check("busy_done", busy, 0);
      check("done_latency", 32'(cyc - last_cyc), 2);
      check("first_pix_latency", 32'(first_vld_cyc - st_cyc), 3);
      check("first_rd_latency", 32'(first_rd_cyc - st_cyc), 2);
      stall_en = 1'b0;
      repeat (20) @(negedge clock);
      check("sb_drained", sb_q.size(), 0);
      check("done_pulses", 32'(fd_cnt - fd0), 1);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0;
      reset = 1'b1;
      start = 1'b0;
      zin   = 1'b0;
      zout  = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_idle("rst");
      @(posedge clock);
      #1 reset = 1'b0;

      run_frame(OP_NORMAL, 1'b0, 1'b0, 1'b0);
      run_frame(OP_NORMAL, 1'b0, 1'b1, 1'b0);
      run_frame(OP_ZIN, 1'b1, 1'b0, 1'b0);

      pulse_btn(1'b0, 1'b1);
      run_frame(OP_NORMAL, 1'b0, 1'b0, 1'b0);
      pulse_btn(1'b0, 1'b1);
      pulse_btn(1'b0, 1'b1);
      run_frame(OP_ZOUT, 1'b1, 1'b0, 1'b0);
      pulse_btn(1'b1, 1'b0);
      pulse_btn(1'b1, 1'b1);
      run_frame(OP_NORMAL, 1'b0, 1'b0, 1'b1);

      pulse_btn(1'b1, 1'b0);
      push_frame(OP_ZIN);
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      acc0 = acc_cnt;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clock);
         if (acc_cnt - acc0 >= 50) break;
      end
      check("pre_reset_progress", (acc_cnt - acc0) >= 50, 1);
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check_idle("rst_mid");
      sb_q.delete();
      run_frame(OP_NORMAL, 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
